instruction_sequencer: RTL and testbench

Fetch/decode/execute controller for the 8-bit CPU. Owns the program counter, fetches variable-length instructions byte-by-byte over the 8-bit memory bus, and assembles the 24-bit instruction word for the instruction decoder's `CBUS`. Handshakes with the datapath for execute completion, branch redirection and halt/resume. Sits between program memory and `instruction_decoder`.

---
 rtl/instruction_sequencer.sv | 105 ++++++++++
 tb/tb_instruction_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode/execute controller: PC, byte-wise fetch, 24-bit CBUS assembly
// Outputs decode registered state/PC only; memory and datapath inputs steer next-state logic.
module instruction_sequencer #(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC = {ADDR_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic              MEM_RDY,
  input  logic [7:0]        MEM_DATA,
  output logic [23:0]       CBUS,
  output logic              CBUS_VLD,
  input  logic              EXEC_DONE,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  input  logic              HALT_REQ,
  input  logic              RESUME,
  output logic              HALTED
);

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [23:0]         cbus_q, cbus_d;
  logic [ADDR_W-1:0]   pc_inc;

  // Transfer, arithmetic and branch classes carry two argument bytes.
  function automatic logic is_long(input logic [7:0] op);
    case (op[7:5])
      3'b001, 3'b010, 3'b011: is_long = 1'b1;
      default:                is_long = 1'b0;
    endcase
  endfunction

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cbus_d  = cbus_q;
    case (state_q)
      S_FETCH0: begin
        if (MEM_RDY) begin
          cbus_d  = {MEM_DATA, 16'h0000};
          pc_d    = pc_inc;
          state_d = is_long(MEM_DATA) ? S_FETCH1 : S_DECODE;
        end
      end
      S_FETCH1: begin
        if (MEM_RDY) begin
          cbus_d[15:8] = MEM_DATA;
          pc_d         = pc_inc;
          state_d      = S_FETCH2;
        end
      end
      S_FETCH2: begin
        if (MEM_RDY) begin
          cbus_d[7:0] = MEM_DATA;
          pc_d        = pc_inc;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (EXEC_DONE) begin
          if (BR_TAKEN) pc_d = BR_TARGET;
          state_d = HALT_REQ ? S_HALTED : S_FETCH0;
        end
      end
      S_HALTED: begin
        if (RESUME) state_d = S_FETCH0;
      end
      default: state_d = S_FETCH0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH0;
      pc_q    <= RESET_VEC;
      cbus_q  <= 24'h000000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cbus_q  <= cbus_d;
    end
  end

  assign MEM_ADDR = pc_q;
  assign MEM_RD   = (state_q == S_FETCH0) || (state_q == S_FETCH1) || (state_q == S_FETCH2);
  assign CBUS     = cbus_q;
  assign CBUS_VLD = (state_q == S_DECODE);
  assign HALTED   = (state_q == S_HALTED);

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed bench for instruction_sequencer with a byte-array program memory
module tb_instruction_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_RDY = 1'b1;
  logic [7:0]  MEM_DATA;
  logic [23:0] CBUS;
  logic        CBUS_VLD;
  logic        EXEC_DONE = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [15:0] BR_TARGET = 16'h0000;
  logic        HALT_REQ = 1'b0;
  logic        RESUME = 1'b0;
  logic        HALTED;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:65535];

  always #5 CLK = ~CLK;

  assign MEM_DATA = mem[MEM_ADDR];

  instruction_sequencer #(.ADDR_W(16), .RESET_VEC(16'h0100)) dut (
    .CLK(CLK), .RST_N(RST_N), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_RDY(MEM_RDY),
    .MEM_DATA(MEM_DATA), .CBUS(CBUS), .CBUS_VLD(CBUS_VLD), .EXEC_DONE(EXEC_DONE),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
    .HALTED(HALTED)
  );

  task automatic step(input logic rdy);
    MEM_RDY = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1);
    step(1'b1);
    total++; if (MEM_ADDR !== 16'h0100) begin bad++; $display("FAIL rst_addr got=%h want=0100", MEM_ADDR); end
    total++; if (CBUS !== 24'h000000) begin bad++; $display("FAIL rst_cbus got=%h want=000000", CBUS); end
    total++; if (CBUS_VLD !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", CBUS_VLD); end
    total++; if (HALTED !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", HALTED); end
    RST_N = 1'b1;
    total++; if (MEM_ADDR !== 16'h0100 || MEM_RD !== 1'b1) begin bad++; $display("FAIL first_fetch got=%h/%b want=0100/1", MEM_ADDR, MEM_RD); end
    step(1'b1);
    total++; if (CBUS !== 24'h050000 || CBUS_VLD !== 1'b1) begin bad++; $display("FAIL rv_decode got=%h/%b want=050000/1", CBUS, CBUS_VLD); end
    total++; if (MEM_ADDR !== 16'h0101) begin bad++; $display("FAIL rv_pc got=%h want=0101", MEM_ADDR); end
    step(1'b1);
    total++; if (CBUS_VLD !== 1'b0 || CBUS !== 24'h050000 || MEM_RD !== 1'b0) begin bad++; $display("FAIL rv_exec got=%b/%h/%b want=0/050000/0", CBUS_VLD, CBUS, MEM_RD); end
    EXEC_DONE = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 16'h0000;
    step(1'b1);
    EXEC_DONE = 1'b0; BR_TAKEN = 1'b0;
    total++; if (MEM_ADDR !== 16'h0000 || MEM_RD !== 1'b1) begin bad++; $display("FAIL rv_branch got=%h/%b want=0000/1", MEM_ADDR, MEM_RD); end
  endtask

  task automatic test_wait_fetch;
    step(1'b0);
    step(1'b0);
    total++; if (MEM_ADDR !== 16'h0000 || MEM_RD !== 1'b1) begin bad++; $display("FAIL wait_hold got=%h/%b want=0000/1", MEM_ADDR, MEM_RD); end
    step(1'b1);
    total++; if (MEM_ADDR !== 16'h0001 || CBUS !== 24'h2A0000) begin bad++; $display("FAIL wait_b0 got=%h/%h want=0001/2A0000", MEM_ADDR, CBUS); end
    step(1'b0);
    step(1'b0);
    step(1'b1);
    total++; if (MEM_ADDR !== 16'h0002 || CBUS !== 24'h2A1200) begin bad++; $display("FAIL wait_b1 got=%h/%h want=0002/2A1200", MEM_ADDR, CBUS); end
    step(1'b0);
    step(1'b0);
    total++; if (CBUS_VLD !== 1'b0 || MEM_ADDR !== 16'h0002) begin bad++; $display("FAIL wait_b2_hold got=%b/%h want=0/0002", CBUS_VLD, MEM_ADDR); end
    step(1'b1);
    total++; if (CBUS !== 24'h2A1234 || CBUS_VLD !== 1'b1 || MEM_ADDR !== 16'h0003) begin bad++; $display("FAIL wait_decode got=%h/%b/%h want=2A1234/1/0003", CBUS, CBUS_VLD, MEM_ADDR); end
    step(1'b1);
    EXEC_DONE = 1'b1;
    step(1'b1);
    EXEC_DONE = 1'b0;
    total++; if (MEM_ADDR !== 16'h0003 || MEM_RD !== 1'b1) begin bad++; $display("FAIL no_branch got=%h/%b want=0003/1", MEM_ADDR, MEM_RD); end
  endtask

  task automatic test_branch;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    total++; if (CBUS !== 24'h610040 || CBUS_VLD !== 1'b1 || MEM_ADDR !== 16'h0006) begin bad++; $display("FAIL br_decode got=%h/%b/%h want=610040/1/0006", CBUS, CBUS_VLD, MEM_ADDR); end
    step(1'b0);
    step(1'b0);
    total++; if (CBUS_VLD !== 1'b0 || MEM_RD !== 1'b0 || HALTED !== 1'b0) begin bad++; $display("FAIL br_exec_wait got=%b/%b/%b want=0/0/0", CBUS_VLD, MEM_RD, HALTED); end
    EXEC_DONE = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 16'h0040;
    step(1'b1);
    EXEC_DONE = 1'b0; BR_TAKEN = 1'b0;
    total++; if (MEM_ADDR !== 16'h0040 || MEM_RD !== 1'b1) begin bad++; $display("FAIL br_target got=%h/%b want=0040/1", MEM_ADDR, MEM_RD); end
  endtask

  task automatic test_halt;
    step(1'b1);
    total++; if (CBUS !== 24'hE00000 || CBUS_VLD !== 1'b1 || MEM_ADDR !== 16'h0041) begin bad++; $display("FAIL misc_decode got=%h/%b/%h want=E00000/1/0041", CBUS, CBUS_VLD, MEM_ADDR); end
    step(1'b0);
    EXEC_DONE = 1'b1; HALT_REQ = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 16'h0200;
    step(1'b0);
    HALT_REQ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (HALTED !== 1'b1 || MEM_RD !== 1'b0 || MEM_ADDR !== 16'h0200 || CBUS !== 24'hE00000) begin bad++; $display("FAIL halted_%0d got=%b/%b/%h/%h want=1/0/0200/E00000", i, HALTED, MEM_RD, MEM_ADDR, CBUS); end
      EXEC_DONE = (i == 4);
      BR_TAKEN  = (i == 4);
      BR_TARGET = 16'h0777;
      step(i[0]);
    end
    EXEC_DONE = 1'b0; BR_TAKEN = 1'b0;
    RESUME = 1'b1;
    step(1'b0);
    RESUME = 1'b0;
    total++; if (MEM_ADDR !== 16'h0200 || MEM_RD !== 1'b1 || HALTED !== 1'b0) begin bad++; $display("FAIL resume got=%h/%b/%b want=0200/1/0", MEM_ADDR, MEM_RD, HALTED); end
  endtask

  task automatic test_wrap;
    step(1'b1);
    step(1'b0);
    EXEC_DONE = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 16'hFFFF;
    step(1'b0);
    EXEC_DONE = 1'b0; BR_TAKEN = 1'b0;
    total++; if (MEM_ADDR !== 16'hFFFF) begin bad++; $display("FAIL wrap_a0 got=%h want=FFFF", MEM_ADDR); end
    step(1'b1);
    total++; if (MEM_ADDR !== 16'h0000 || MEM_RD !== 1'b1) begin bad++; $display("FAIL wrap_a1 got=%h/%b want=0000/1", MEM_ADDR, MEM_RD); end
    step(1'b1);
    total++; if (MEM_ADDR !== 16'h0001) begin bad++; $display("FAIL wrap_a2 got=%h want=0001", MEM_ADDR); end
    step(1'b1);
    total++; if (CBUS !== 24'h412A12 || CBUS_VLD !== 1'b1 || MEM_ADDR !== 16'h0002) begin bad++; $display("FAIL wrap_decode got=%h/%b/%h want=412A12/1/0002", CBUS, CBUS_VLD, MEM_ADDR); end
    step(1'b0);
    EXEC_DONE = 1'b1;
    step(1'b0);
    EXEC_DONE = 1'b0;
    total++; if (MEM_ADDR !== 16'h0002 || MEM_RD !== 1'b1) begin bad++; $display("FAIL wrap_next got=%h/%b want=0002/1", MEM_ADDR, MEM_RD); end
  endtask

  task automatic test_reset_mid;
    step(1'b1);
    total++; if (CBUS !== 24'h340000 || MEM_ADDR !== 16'h0003) begin bad++; $display("FAIL mid_f1 got=%h/%h want=340000/0003", CBUS, MEM_ADDR); end
    RST_N = 1'b0;
    #1;
    total++; if (CBUS !== 24'h000000 || CBUS_VLD !== 1'b0 || MEM_ADDR !== 16'h0100) begin bad++; $display("FAIL mid_rst_f1 got=%h/%b/%h want=000000/0/0100", CBUS, CBUS_VLD, MEM_ADDR); end
    @(negedge CLK);
    RST_N = 1'b1;
    EXEC_DONE = 1'b1; BR_TAKEN = 1'b1; HALT_REQ = 1'b1; BR_TARGET = 16'h0777;
    step(1'b1);
    total++; if (CBUS !== 24'h050000 || CBUS_VLD !== 1'b1 || MEM_ADDR !== 16'h0101) begin bad++; $display("FAIL mid_refetch got=%h/%b/%h want=050000/1/0101", CBUS, CBUS_VLD, MEM_ADDR); end
    step(1'b1);
    EXEC_DONE = 1'b0; BR_TAKEN = 1'b0; HALT_REQ = 1'b0;
    total++; if (HALTED !== 1'b0 || MEM_RD !== 1'b0 || MEM_ADDR !== 16'h0101 || CBUS_VLD !== 1'b0) begin bad++; $display("FAIL stray_ignored got=%b/%b/%h/%b want=0/0/0101/0", HALTED, MEM_RD, MEM_ADDR, CBUS_VLD); end
    RST_N = 1'b0;
    #1;
    total++; if (CBUS !== 24'h000000 || CBUS_VLD !== 1'b0 || MEM_ADDR !== 16'h0100 || HALTED !== 1'b0) begin bad++; $display("FAIL mid_rst_exec got=%h/%b/%h/%b want=000000/0/0100/0", CBUS, CBUS_VLD, MEM_ADDR, HALTED); end
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b1);
    total++; if (CBUS !== 24'h050000 || CBUS_VLD !== 1'b1) begin bad++; $display("FAIL mid_refetch2 got=%h/%b want=050000/1", CBUS, CBUS_VLD); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h2A; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h34;
    mem[16'h0003] = 8'h61; mem[16'h0004] = 8'h00; mem[16'h0005] = 8'h40;
    mem[16'h0040] = 8'hE0;
    mem[16'h0100] = 8'h05;
    mem[16'h0200] = 8'h00;
    mem[16'hFFFF] = 8'h41;
    test_reset();
    test_wait_fetch();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
